// File: rtl/matrix_3x3_gen.sv
`default_nettype none
// ============================================================================
// matrix_3x3_gen : 3x3 neighbourhood generator for a raster grey stream,
//                  built from two line buffers and a two-stage pipeline.
// Option macro   : BORDER_REPLICATE_EN (edge replication instead of zero pad)
// Revision       : 1.0 - initial release
// ============================================================================
module matrix_3x3_gen #(
  parameter int IMG_WIDTH = 1280,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 11
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              in_vs,
  input  logic              in_hs,
  input  logic              in_de,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] matrix11,
  output logic [DATA_W-1:0] matrix12,
  output logic [DATA_W-1:0] matrix13,
  output logic [DATA_W-1:0] matrix21,
  output logic [DATA_W-1:0] matrix22,
  output logic [DATA_W-1:0] matrix23,
  output logic [DATA_W-1:0] matrix31,
  output logic [DATA_W-1:0] matrix32,
  output logic [DATA_W-1:0] matrix33,
  output logic              matrix_de,
  output logic              matrix_hs,
  output logic              matrix_vs
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] COL_LIMIT = (ADDR_W + 1)'(IMG_WIDTH);

  logic [DATA_W-1:0] lb_a [DEPTH];
  logic [DATA_W-1:0] lb_b [DEPTH];

  logic [ADDR_W:0]   col_cnt;
  logic [1:0]        row_cnt;
  logic              de_prev;
  logic              vs_prev;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              de_fall;
  logic              vs_rise;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] row1_px;
  logic [DATA_W-1:0] row2_px;

  logic              s1_de;
  logic              s1_hs;
  logic              s1_vs;
  logic              s1_first;
  logic [DATA_W-1:0] s1_r1;
  logic [DATA_W-1:0] s1_r2;
  logic [DATA_W-1:0] s1_r3;
  logic [DATA_W-1:0] pad1;
  logic [DATA_W-1:0] pad2;
  logic [DATA_W-1:0] pad3;

  // Pixels beyond the configured width are dropped: no write, no window update.
  assign addr    = col_cnt[ADDR_W-1:0];
  assign wr_en   = in_de && (col_cnt < COL_LIMIT) && !rst;
  assign de_fall = de_prev && !in_de;
  assign vs_rise = in_vs && !vs_prev;
  assign rd_a    = lb_a[addr];
  assign rd_b    = lb_b[addr];

  always_comb begin
    row2_px = rd_a;
    row1_px = rd_b;
`ifdef BORDER_REPLICATE_EN
    if (row_cnt == 2'd0) row2_px = in_data;
    if (row_cnt <= 2'd1) row1_px = row2_px;
`else
    if (row_cnt == 2'd0) row2_px = '0;
    if (row_cnt <= 2'd1) row1_px = '0;
`endif
  end

`ifdef BORDER_REPLICATE_EN
  assign pad1 = s1_r1;
  assign pad2 = s1_r2;
  assign pad3 = s1_r3;
`else
  assign pad1 = '0;
  assign pad2 = '0;
  assign pad3 = '0;
`endif

  // Read-before-write: lb_b receives the line that lb_a held until now.
  always_ff @(posedge video_clk) begin
    if (wr_en) begin
      lb_a[addr] <= in_data;
      lb_b[addr] <= rd_a;
    end
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      de_prev <= in_de;
      vs_prev <= in_vs;
      if (de_fall) begin
        col_cnt <= '0;
      end else if (in_de && (col_cnt != '1)) begin
        col_cnt <= col_cnt + 1'b1;
      end
      if (vs_rise) begin
        row_cnt <= '0;
      end else if (de_fall && (row_cnt != 2'd3)) begin
        row_cnt <= row_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      s1_de    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_first <= 1'b0;
      s1_r1    <= '0;
      s1_r2    <= '0;
      s1_r3    <= '0;
    end else begin
      s1_de    <= wr_en;
      s1_hs    <= in_hs;
      s1_vs    <= in_vs;
      s1_first <= (col_cnt == '0);
      s1_r1    <= row1_px;
      s1_r2    <= row2_px;
      s1_r3    <= in_data;
    end
  end

  always_ff @(posedge video_clk) begin
    if (rst) begin
      matrix_de <= 1'b0;
      matrix_hs <= 1'b0;
      matrix_vs <= 1'b0;
      matrix11  <= '0;
      matrix12  <= '0;
      matrix13  <= '0;
      matrix21  <= '0;
      matrix22  <= '0;
      matrix23  <= '0;
      matrix31  <= '0;
      matrix32  <= '0;
      matrix33  <= '0;
    end else begin
      matrix_de <= s1_de;
      matrix_hs <= s1_hs;
      matrix_vs <= s1_vs;
      if (s1_de) begin
        matrix13 <= s1_r1;
        matrix23 <= s1_r2;
        matrix33 <= s1_r3;
        if (s1_first) begin
          matrix11 <= pad1;
          matrix12 <= pad1;
          matrix21 <= pad2;
          matrix22 <= pad2;
          matrix31 <= pad3;
          matrix32 <= pad3;
        end else begin
          matrix11 <= matrix12;
          matrix12 <= matrix13;
          matrix21 <= matrix22;
          matrix22 <= matrix23;
          matrix31 <= matrix32;
          matrix32 <= matrix33;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_3x3_gen.sv
`default_nettype none
// tb_matrix_3x3_gen : directed + random stimulus against a frame-level reference model.
module tb_matrix_3x3_gen;

  localparam int W  = 4;
  localparam int AW = 2;
  localparam int DW = 8;
`ifdef BORDER_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [71:0] win;
  } exp_t;

  logic          video_clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_vs = 1'b0;
  logic          in_hs = 1'b0;
  logic          in_de = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] matrix11, matrix12, matrix13;
  logic [DW-1:0] matrix21, matrix22, matrix23;
  logic [DW-1:0] matrix31, matrix32, matrix33;
  logic          matrix_de, matrix_hs, matrix_vs;
  logic [71:0]   dut_win;

  int            n_assert = 0;
  int            n_fail   = 0;

  // Reference model state: line memories per column, 3x3 window, line/pixel counters.
  int            m_row = 0;
  int            m_col = 0;
  bit            m_de_p = 1'b0;
  bit            m_vs_p = 1'b0;
  logic [7:0]    line_a [W];
  logic [7:0]    line_b [W];
  logic [7:0]    win [3][3];
  exp_t          exp_prev = '0;

  matrix_3x3_gen #(.IMG_WIDTH(W), .DATA_W(DW), .ADDR_W(AW)) dut (
    .video_clk (video_clk),
    .rst       (rst),
    .in_vs     (in_vs),
    .in_hs     (in_hs),
    .in_de     (in_de),
    .in_data   (in_data),
    .matrix11  (matrix11),
    .matrix12  (matrix12),
    .matrix13  (matrix13),
    .matrix21  (matrix21),
    .matrix22  (matrix22),
    .matrix23  (matrix23),
    .matrix31  (matrix31),
    .matrix32  (matrix32),
    .matrix33  (matrix33),
    .matrix_de (matrix_de),
    .matrix_hs (matrix_hs),
    .matrix_vs (matrix_vs)
  );

  assign dut_win = {matrix11, matrix12, matrix13, matrix21, matrix22, matrix23,
                    matrix31, matrix32, matrix33};

  always #5 video_clk = ~video_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] pack_win();
    logic [71:0] res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        res = {res[63:0], win[r][c]};
    return res;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs seen after this edge belong to the previous step's input.
  task automatic step(input bit r, input bit de, input bit hs, input bit vs, input logic [7:0] d);
    exp_t       cur;
    bit         valid, de_fall, vs_rise;
    logic [7:0] nc [3];
    rst = r; in_de = de; in_hs = hs; in_vs = vs; in_data = d;
    if (r) begin
      m_row = 0; m_col = 0; m_de_p = 0; m_vs_p = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] = 8'h00;
      cur = '0;
    end else begin
      valid = de && (m_col < W);
      if (valid) begin
        nc[2] = d;
        nc[1] = (m_row == 0) ? (REP ? d : 8'h00) : line_a[m_col];
        nc[0] = (m_row <= 1) ? (REP ? nc[1] : 8'h00) : line_b[m_col];
        line_b[m_col] = line_a[m_col];
        line_a[m_col] = d;
        for (int i = 0; i < 3; i++) begin
          if (m_col == 0) begin
            win[i][0] = REP ? nc[i] : 8'h00;
            win[i][1] = REP ? nc[i] : 8'h00;
          end else begin
            win[i][0] = win[i][1];
            win[i][1] = win[i][2];
          end
          win[i][2] = nc[i];
        end
      end
      cur.de  = valid;
      cur.hs  = hs;
      cur.vs  = vs;
      cur.win = pack_win();
      de_fall = m_de_p && !de;
      vs_rise = vs && !m_vs_p;
      if (de_fall) m_col = 0;
      else if (de) m_col++;
      if (vs_rise) m_row = 0;
      else if (de_fall && m_row < 3) m_row++;
      m_de_p = de;
      m_vs_p = vs;
    end
    @(posedge video_clk);
    #1;
    if (r) exp_prev = '0;
    check("ctl_de_hs_vs", {69'd0, matrix_de, matrix_hs, matrix_vs},
          {69'd0, exp_prev.de, exp_prev.hs, exp_prev.vs});
    check("window", dut_win, exp_prev.win);
    exp_prev = cur;
  endtask

  task automatic line(input int n, input int base, input bit rnd);
    for (int c = 0; c < n; c++)
      step(0, 1, 0, 0, rnd ? 8'($urandom) : 8'(base + c));
  endtask

  task automatic gap(input int n, input bit hs_first);
    for (int i = 0; i < n; i++)
      step(0, 0, hs_first && (i == 0), 0, 8'h00);
  endtask

  task automatic vs_pulse();
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    logic [71:0] exp55;
    logic [71:0] saved;
    for (int i = 0; i < W; i++) begin
      line_a[i] = 8'h00;
      line_b[i] = 8'h00;
    end
    exp55 = REP ? {9{8'h55}} : 72'h55;

    // Reset state
    step(1, 0, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h00);
    check("reset_win", dut_win, 72'h0);

    // Frame of pixel = 16*row + col
    vs_pulse();
    line(W, 8'h00, 0); gap(2, 1);
    line(W, 8'h10, 0); gap(2, 1);
    line(W, 8'h20, 0);
    check("spec_px22_win", dut_win, 72'h000102_101112_202122);
    check("spec_px22_de", {71'd0, matrix_de}, 72'd1);
    gap(2, 1);

    // de gap of 3 clk after two pixels: window frozen while de low
    line(2, 8'h30, 0);
    step(0, 0, 0, 0, 8'h00);
    saved = dut_win;
    step(0, 0, 0, 0, 8'h00);
    check("gap_frozen_1", dut_win, saved);
    step(0, 0, 0, 0, 8'h00);
    check("gap_frozen_2", dut_win, saved);
    check("gap_de_low", {71'd0, matrix_de}, 72'd0);
    line(2, 8'h32, 0); gap(2, 1);

    // vs after a line: next line is row 0, first pixel 0x55 at column 0
    vs_pulse();
    step(0, 1, 0, 0, 8'h55);
    step(0, 0, 0, 0, 8'h00);
    check("row0_col0_55", dut_win, exp55);
    gap(1, 1);
    line(W, 8'h60, 0); gap(2, 1);
    line(W, 8'h70, 0); gap(2, 1);

    // Reset for one clock mid-line, then padded restart
    line(2, 8'h80, 0);
    step(1, 1, 0, 0, 8'h82);
    check("midline_rst_win", dut_win, 72'h0);
    line(2, 8'h83, 0); gap(2, 1);
    line(W, 8'h90, 0); gap(2, 1);
    line(W, 8'hA0, 0); gap(2, 1);

    // Overlong line: pixels past IMG_WIDTH are dropped
    line(6, 8'hB0, 0); gap(2, 1);
    line(W, 8'hC0, 0); gap(2, 1);
    line(W, 8'hD0, 0); gap(2, 1);

    // Randomised frames
    for (int f = 0; f < 6; f++) begin
      vs_pulse();
      for (int l = 0; l < 4; l++) begin
        line($urandom_range(6, 4), 0, 1);
        gap($urandom_range(3, 1), 1'($urandom));
      end
    end
    gap(3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
